// File: rtl/axil_master_port.sv
// rtl/axil_master_port.sv - single-outstanding AXI4-Lite master driven by a simple command/response port
//
// Purpose:
//   Turns one user command (read or write) into one AXI4-Lite transaction and
//   returns a single completion carrying the read data and the slave's response
//   code. Only one transaction is in flight at a time.
//
// Ports:
//   clk, rst                       clock (rising edge) and synchronous active-high reset
//   cmd_valid/cmd_ready            command handshake; cmd_write selects write (1) / read (0)
//   cmd_addr, cmd_wdata            target byte address and write data
//   rsp_valid/rsp_ready            completion handshake
//   rsp_data, rsp_resp             read data (0 for writes) and captured BRESP/RRESP
//   m_axil_aw*/w*/b*               AXI4-Lite write address, write data and write response channels
//   m_axil_ar*/r*                  AXI4-Lite read address and read data channels
module axil_master_port #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [DATA_WIDTH-1:0] cmd_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_data,
   output logic [1:0]            rsp_resp,
   output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
   output logic                  m_axil_awvalid,
   input  logic                  m_axil_awready,
   output logic [DATA_WIDTH-1:0] m_axil_wdata,
   output logic [STRB_WIDTH-1:0] m_axil_wstrb,
   output logic                  m_axil_wvalid,
   input  logic                  m_axil_wready,
   input  logic [1:0]            m_axil_bresp,
   input  logic                  m_axil_bvalid,
   output logic                  m_axil_bready,
   output logic [ADDR_WIDTH-1:0] m_axil_araddr,
   output logic                  m_axil_arvalid,
   input  logic                  m_axil_arready,
   input  logic [DATA_WIDTH-1:0] m_axil_rdata,
   input  logic [1:0]            m_axil_rresp,
   input  logic                  m_axil_rvalid,
   output logic                  m_axil_rready
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR_REQ  = 3'd1,
      WR_RESP = 3'd2,
      RD_REQ  = 3'd3,
      RD_DATA = 3'd4,
      RSP     = 3'd5
   } state_t;

   state_t                state;
   state_t                state_next;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic                  aw_done;
   logic                  w_done;
   logic [DATA_WIDTH-1:0] rsp_data_q;
   logic [1:0]            rsp_resp_q;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic. WR_REQ exits on the registered done flags, so the
   // AW and W handshakes may finish in any order, or in the same cycle.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (cmd_valid) state_next = cmd_write ? WR_REQ : RD_REQ;
         WR_REQ:  if (aw_done && w_done) state_next = WR_RESP;
         WR_RESP: if (m_axil_bvalid) state_next = RSP;
         RD_REQ:  if (m_axil_arready) state_next = RD_DATA;
         RD_DATA: if (m_axil_rvalid) state_next = RSP;
         RSP:     if (rsp_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Output logic. Everything is forced quiet while rst is high, including
   // the first reset cycle before the state register has returned to IDLE.
   always_comb begin
      cmd_ready      = 1'b0;
      m_axil_awvalid = 1'b0;
      m_axil_wvalid  = 1'b0;
      m_axil_bready  = 1'b0;
      m_axil_arvalid = 1'b0;
      m_axil_rready  = 1'b0;
      rsp_valid      = 1'b0;
      rsp_data       = rsp_data_q;
      rsp_resp       = rsp_resp_q;
      if (rst) begin
         rsp_data = '0;
         rsp_resp = 2'b00;
      end else begin
         case (state)
            IDLE:    cmd_ready = 1'b1;
            WR_REQ: begin
               m_axil_awvalid = !aw_done;
               m_axil_wvalid  = !w_done;
            end
            WR_RESP: m_axil_bready  = 1'b1;
            RD_REQ:  m_axil_arvalid = 1'b1;
            RD_DATA: m_axil_rready  = 1'b1;
            RSP:     rsp_valid      = 1'b1;
            default: cmd_ready      = 1'b0;
         endcase
      end
   end

   assign m_axil_awaddr = addr_q;
   assign m_axil_araddr = addr_q;
   assign m_axil_wdata  = wdata_q;
   assign m_axil_wstrb  = {STRB_WIDTH{1'b1}};

   // Command capture, per-channel handshake tracking and response capture
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q     <= '0;
         wdata_q    <= '0;
         aw_done    <= 1'b0;
         w_done     <= 1'b0;
         rsp_data_q <= '0;
         rsp_resp_q <= 2'b00;
      end else begin
         if (state == IDLE && cmd_valid) begin
            addr_q  <= cmd_addr;
            wdata_q <= cmd_wdata;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
         end
         if (state == WR_REQ) begin
            if (m_axil_awvalid && m_axil_awready) aw_done <= 1'b1;
            if (m_axil_wvalid && m_axil_wready) w_done <= 1'b1;
         end
         if (state == WR_RESP && m_axil_bvalid) begin
            rsp_data_q <= '0;
            rsp_resp_q <= m_axil_bresp;
         end
         if (state == RD_DATA && m_axil_rvalid) begin
            rsp_data_q <= m_axil_rdata;
            rsp_resp_q <= m_axil_rresp;
         end
      end
   end

endmodule

// File: tb/tb_axil_master_port.sv
// tb/tb_axil_master_port.sv - directed self-checking bench for axil_master_port
module tb_axil_master_port;

   logic        clk;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_write;
   logic [4:0]  cmd_addr;
   logic [31:0] cmd_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data;
   logic [1:0]  rsp_resp;
   logic [4:0]  awaddr;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;
   logic [4:0]  araddr;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;

   axil_master_port #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_resp(rsp_resp),
      .m_axil_awaddr(awaddr), .m_axil_awvalid(awvalid), .m_axil_awready(awready),
      .m_axil_wdata(wdata), .m_axil_wstrb(wstrb), .m_axil_wvalid(wvalid), .m_axil_wready(wready),
      .m_axil_bresp(bresp), .m_axil_bvalid(bvalid), .m_axil_bready(bready),
      .m_axil_araddr(araddr), .m_axil_arvalid(arvalid), .m_axil_arready(arready),
      .m_axil_rdata(rdata), .m_axil_rresp(rresp), .m_axil_rvalid(rvalid), .m_axil_rready(rready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Slave model: 8-word RAM, configurable AW delay, response codes and read stall
   logic [1:0]  cfg_bresp;
   logic [1:0]  cfg_rresp;
   int          cfg_aw_delay;
   logic        cfg_r_hold;
   logic [31:0] mem [0:7];
   int          aw_wait;
   logic        aw_got;
   logic        w_got;
   logic [2:0]  aw_idx;
   logic [31:0] w_dat;

   assign awready = (aw_wait >= cfg_aw_delay);
   assign wready  = 1'b1;
   assign arready = 1'b1;

   always @(posedge clk) begin
      if (rst) begin
         aw_wait <= 0;
         aw_got  <= 1'b0;
         w_got   <= 1'b0;
         aw_idx  <= 3'd0;
         w_dat   <= 32'd0;
         bvalid  <= 1'b0;
         bresp   <= 2'b00;
         rvalid  <= 1'b0;
         rresp   <= 2'b00;
         rdata   <= 32'd0;
      end else begin
         if (awvalid && !awready) aw_wait <= aw_wait + 1;
         else aw_wait <= 0;
         if (awvalid && awready) begin
            aw_got <= 1'b1;
            aw_idx <= awaddr[4:2];
         end
         if (wvalid && wready) begin
            w_got <= 1'b1;
            w_dat <= wdata;
         end
         if (aw_got && w_got) begin
            mem[aw_idx] <= w_dat;
            aw_got      <= 1'b0;
            w_got       <= 1'b0;
            bvalid      <= 1'b1;
            bresp       <= cfg_bresp;
         end else if (bvalid && bready) begin
            bvalid <= 1'b0;
         end
         if (arvalid && arready && !cfg_r_hold) begin
            rvalid <= 1'b1;
            rdata  <= mem[araddr[4:2]];
            rresp  <= cfg_rresp;
         end else if (rvalid && rready) begin
            rvalid <= 1'b0;
         end
      end
   end

   // Activity counters
   logic cnt_clr;
   logic bready_d;
   int   cnt_aw_hs, cnt_w_hs, cnt_ar_hs, cnt_awv, cnt_wv, cnt_bphase, cnt_rsp;

   always @(posedge clk) begin
      bready_d <= bready;
      if (cnt_clr) begin
         cnt_aw_hs  <= 0;
         cnt_w_hs   <= 0;
         cnt_ar_hs  <= 0;
         cnt_awv    <= 0;
         cnt_wv     <= 0;
         cnt_bphase <= 0;
         cnt_rsp    <= 0;
      end else begin
         if (awvalid && awready) cnt_aw_hs <= cnt_aw_hs + 1;
         if (wvalid && wready) cnt_w_hs <= cnt_w_hs + 1;
         if (arvalid && arready) cnt_ar_hs <= cnt_ar_hs + 1;
         if (awvalid) cnt_awv <= cnt_awv + 1;
         if (wvalid) cnt_wv <= cnt_wv + 1;
         if (bready && !bready_d) cnt_bphase <= cnt_bphase + 1;
         if (rsp_valid) cnt_rsp <= cnt_rsp + 1;
      end
   end

   int n_run;
   int n_fail;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_run++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clr_counts();
      cnt_clr = 1'b1;
      @(negedge clk);
      cnt_clr = 1'b0;
   endtask

   // Offer one command while IDLE; returns at the negedge after the accept edge
   task automatic issue(input logic w, input logic [4:0] a, input logic [31:0] d);
      cmd_write = w;
      cmd_addr  = a;
      cmd_wdata = d;
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   // Latency counts the accept cycle as cycle 1
   task automatic wait_rsp(output int lat);
      lat = 1;
      while (!rsp_valid && lat < 60) begin
         @(negedge clk);
         lat++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   int lat;
   int ok;

   initial begin
      n_run        = 0;
      n_fail       = 0;
      rst          = 1'b1;
      cmd_valid    = 1'b0;
      cmd_write    = 1'b0;
      cmd_addr     = 5'd0;
      cmd_wdata    = 32'd0;
      rsp_ready    = 1'b1;
      cfg_bresp    = 2'b00;
      cfg_rresp    = 2'b00;
      cfg_aw_delay = 0;
      cfg_r_hold   = 1'b0;
      cnt_clr      = 1'b1;

      // Reset state
      repeat (3) @(negedge clk);
      chk("reset_cmd_ready", cmd_ready, 0);
      chk("reset_valids", {awvalid, wvalid, arvalid, bready, rready, rsp_valid}, 0);
      chk("reset_rsp_data", rsp_data, 0);
      chk("reset_rsp_resp", rsp_resp, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("cmd_ready_after_rst", cmd_ready, 1);
      chk("wstrb_all_ones", wstrb, 4'hF);

      // Write 2345 to address 4
      clr_counts();
      issue(1'b1, 5'd4, 32'd2345);
      wait_rsp(lat);
      chk("wr_latency", lat, 4);
      chk("wr_rsp_resp", rsp_resp, 0);
      chk("wr_rsp_data", rsp_data, 0);
      chk("wr_cmd_ready_busy", cmd_ready, 0);
      @(negedge clk);
      chk("wr_rsp_pulse", rsp_valid, 0);
      chk("wr_aw_handshakes", cnt_aw_hs, 1);
      chk("wr_w_handshakes", cnt_w_hs, 1);
      chk("wr_rsp_cycles", cnt_rsp, 1);
      chk("wr_cmd_ready_back", cmd_ready, 1);

      // Read it back
      clr_counts();
      issue(1'b0, 5'd4, 32'hDEADBEEF);
      wait_rsp(lat);
      chk("rd_latency", lat, 3);
      chk("rd_data", rsp_data, 32'd2345);
      chk("rd_resp", rsp_resp, 0);
      @(negedge clk);
      chk("rd_ar_handshakes", cnt_ar_hs, 1);
      chk("rd_rsp_pulse", rsp_valid, 0);

      // Skewed handshakes: AW ready after 3 wait cycles, W immediate
      cfg_aw_delay = 3;
      clr_counts();
      issue(1'b1, 5'd8, 32'h0000ABCD);
      chk("sk_both_valid", {awvalid, wvalid}, 2'b11);
      @(negedge clk);
      chk("sk_w_dropped", {awvalid, wvalid}, 2'b10);
      wait_rsp(lat);
      chk("sk_rsp_valid", rsp_valid, 1);
      chk("sk_rsp_resp", rsp_resp, 0);
      @(negedge clk);
      chk("sk_awvalid_cycles", cnt_awv, 4);
      chk("sk_wvalid_cycles", cnt_wv, 1);
      chk("sk_bready_phases", cnt_bphase, 1);
      chk("sk_aw_handshakes", cnt_aw_hs, 1);
      cfg_aw_delay = 0;
      issue(1'b0, 5'd8, 32'd0);
      wait_rsp(lat);
      chk("sk_readback", rsp_data, 32'h0000ABCD);
      @(negedge clk);

      // SLVERR write response with 5 cycles of completion backpressure
      cfg_bresp = 2'b10;
      rsp_ready = 1'b0;
      issue(1'b1, 5'd12, 32'd77);
      wait_rsp(lat);
      chk("be_latency", lat, 4);
      ok = 0;
      for (int i = 0; i < 5; i++) begin
         if (rsp_valid && rsp_resp == 2'b10 && rsp_data == 32'd0 && !cmd_ready) ok++;
         @(negedge clk);
      end
      chk("be_stable_cycles", ok, 5);
      chk("be_still_valid", rsp_valid, 1);
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("be_released", {rsp_valid, cmd_ready}, 2'b01);
      cfg_bresp = 2'b00;

      // DECERR on read passed through with the data
      cfg_rresp = 2'b11;
      issue(1'b0, 5'd4, 32'd0);
      wait_rsp(lat);
      chk("rderr_resp", rsp_resp, 2'b11);
      chk("rderr_data", rsp_data, 32'd2345);
      @(negedge clk);
      cfg_rresp = 2'b00;

      // Reset while waiting in RD_DATA
      cfg_r_hold = 1'b1;
      clr_counts();
      issue(1'b0, 5'd4, 32'd0);
      chk("rr_arvalid", arvalid, 1);
      @(negedge clk);
      chk("rr_rready", rready, 1);
      rst = 1'b1;
      @(negedge clk);
      chk("rr_quiet", {awvalid, wvalid, arvalid, bready, rready, rsp_valid, cmd_ready}, 0);
      rst        = 1'b0;
      cfg_r_hold = 1'b0;
      @(negedge clk);
      chk("rr_cmd_ready", cmd_ready, 1);
      repeat (4) @(negedge clk);
      chk("rr_no_rsp", cnt_rsp, 0);
      issue(1'b0, 5'd4, 32'd0);
      wait_rsp(lat);
      chk("rr_recover_data", rsp_data, 32'd2345);
      @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule

// File: doc/axil_master_port.md
AXIL_MASTER_PORT -- requirements
Module: axil_master_port
Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data bus width in bits; STRB_WIDTH is fixed internally at DATA_WIDTH/8.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, AXI-Lite byte address width.
REQ-003 SHALL have port clk  input  1  clock; all logic rising-edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port cmd_valid  input  1  user command offered.
REQ-006 SHALL have port cmd_ready  output  1  block accepts a command this cycle.
REQ-007 SHALL have port cmd_write  input  1  1 = write, 0 = read.
REQ-008 SHALL have port cmd_addr  input  ADDR_WIDTH  target address.
REQ-009 SHALL have port cmd_wdata  input  DATA_WIDTH  write data; ignored for reads.
REQ-010 SHALL have port rsp_valid  output  1  completion available.
REQ-011 SHALL have port rsp_ready  input  1  user consumes completion.
REQ-012 SHALL have port rsp_data  output  DATA_WIDTH  read data; 0 for writes.
REQ-013 SHALL have port rsp_resp  output  2  captured BRESP or RRESP.
REQ-014 SHALL have port m_axil_awaddr  output  ADDR_WIDTH  write address.
REQ-015 SHALL have port m_axil_awvalid  output  1  write address valid.
REQ-016 SHALL have port m_axil_awready  input  1  slave accepts address.
REQ-017 SHALL have port m_axil_wdata  output  DATA_WIDTH  write data.
REQ-018 SHALL have port m_axil_wstrb  output  STRB_WIDTH  byte strobes, constant all ones.
REQ-019 SHALL have port m_axil_wvalid  output  1  write data valid.
REQ-020 SHALL have port m_axil_wready  input  1  slave accepts data.
REQ-021 SHALL have port m_axil_bresp  input  2  write response code.
REQ-022 SHALL have port m_axil_bvalid  input  1  write response valid.
REQ-023 SHALL have port m_axil_bready  output  1  master accepts write response.
REQ-024 SHALL have port m_axil_araddr  output  ADDR_WIDTH  read address.
REQ-025 SHALL have port m_axil_arvalid  output  1  read address valid.
REQ-026 SHALL have port m_axil_arready  input  1  slave accepts read address.
REQ-027 SHALL have port m_axil_rdata  input  DATA_WIDTH  read data.
REQ-028 SHALL have port m_axil_rresp  input  2  read response code.
REQ-029 SHALL have port m_axil_rvalid  input  1  read data valid.
REQ-030 SHALL have port m_axil_rready  output  1  master accepts read data.
Function
REQ-031 SHALL implement FSM states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP; one transaction outstanding at a time.
REQ-032 SHALL assert cmd_ready only in IDLE; on cmd_valid&&cmd_ready, register addr/wdata and go to WR_REQ (cmd_write=1) or RD_REQ (cmd_write=0).
REQ-033 SHALL, on entering WR_REQ, assert awvalid and wvalid together; each drops the cycle after its own ready is sampled high, independently; addr/data stay stable while their valid is high.
REQ-034 SHALL leave WR_REQ for WR_RESP once both AW and W handshakes have completed, including the case where both complete in the same cycle.
REQ-035 SHALL drive bready=1 only in WR_RESP; on bvalid capture bresp, set rsp_data=0, go to RSP.
REQ-036 SHALL hold arvalid in RD_REQ until arready is sampled high, then go to RD_DATA.
REQ-037 SHALL drive rready=1 only in RD_DATA; on rvalid capture rdata and rresp, go to RSP.
REQ-038 SHALL hold rsp_valid=1 with stable rsp_data/rsp_resp in RSP until rsp_ready; then return to IDLE. A new command is accepted no earlier than the following cycle.
REQ-039 SHALL pass non-OKAY responses (SLVERR/DECERR) to rsp_resp unchanged, with no retry.
REQ-040 SHALL never assert a valid on a channel whose state is inactive; bvalid/rvalid outside WR_RESP/RD_DATA are ignored.
REQ-041 SHALL complete a write in 4 cycles, from command accept to rsp_valid, against a slave with single-cycle ready and response; a read SHALL complete in 3 cycles.
Reset
REQ-042 SHALL, while rst is high, enter IDLE and drive awvalid=wvalid=arvalid=bready=rready=rsp_valid=0, cmd_ready=0, rsp_data=0, rsp_resp=0; cmd_ready=1 the cycle after rst falls.
REQ-043 SHALL abandon any in-flight transaction on reset mid-operation without emitting a response; the slave SHALL be reset together with this block.
Verification
REQ-044 Write to axil_ram (32/5): write addr 4, data 2345, rsp_ready=1 -> AW/W each accepted once, rsp_valid pulses with rsp_resp=0, rsp_data=0.
REQ-045 Readback: after REQ-044, read addr 4 -> rsp_data=2345, rsp_resp=0, exactly one arvalid handshake.
REQ-046 Skewed handshakes: stub slave with awready delayed 3 cycles and wready immediate -> wvalid drops after 1 cycle, awvalid after 4, single bready phase.
REQ-047 Backpressure and error: stub returns bresp=2'b10 and rsp_ready is held low 5 cycles -> rsp_valid/rsp_resp=2 stable for 5 cycles, cmd_ready=0 throughout.
REQ-048 Reset in RD_DATA: rst pulsed 1 cycle -> all valids/readies 0 next cycle, no rsp_valid, cmd_ready=1 after rst falls.
